// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: run-control sequencer for the 4-bit CPU core.
// Fetches over req/ack and strobes execute exactly once per instruction.
module cpu_seq_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             step_i,
    input  logic             bp_en_i,
    input  logic [3:0]       bp_addr_i,
    input  logic [3:0]       ip_i,
    output logic             rom_req_o,
    output logic [3:0]       rom_addr_o,
    input  logic             rom_ack_i,
    input  logic [7:0]       rom_data_i,
    output logic             exec_en_o,
    output logic [7:0]       instr_o,
    output logic             halted_o,
    output logic             bp_hit_o,
    output logic             selfloop_o,
    output logic             err_o,
    input  logic             clr_err_i,
    input  logic             clr_cnt_i,
    output logic [CNT_W-1:0] insn_count_o
);

    typedef enum logic [2:0] {
        S_HALT,
        S_FETCH,
        S_EXEC,
        S_CHECK,
        S_ERROR
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_run;
    logic             w_run_nxt;
    logic             r_halted;
    logic [3:0]       r_addr;
    logic [7:0]       r_instr;
    logic [7:0]       r_to;
    logic             r_bp_hit;
    logic             r_selfloop;
    logic [CNT_W-1:0] r_cnt;
    logic             w_to_hit;
    logic             w_selfloop;
    logic             w_bp;
    logic             w_set_bp;
    logic             w_set_sl;
    logic             w_enter_fetch;
    logic             w_leave_halt;

    assign w_to_hit   = (r_to == 8'(TIMEOUT - 1));
    assign w_selfloop = (r_instr[7:4] == 4'hF) && (r_instr[3:0] == r_addr);
    assign w_bp       = bp_en_i && (ip_i == bp_addr_i);

    always_comb begin
        w_next    = r_state;
        w_run_nxt = r_run;
        w_set_bp  = 1'b0;
        w_set_sl  = 1'b0;
        unique case (r_state)
            S_HALT: begin
                if (start_i && !stop_i) begin
                    w_next    = S_FETCH;
                    w_run_nxt = 1'b1;
                end else if (step_i && !start_i) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (rom_ack_i) begin
                    w_next = S_EXEC;
                end else if (w_to_hit) begin
                    w_next    = S_ERROR;
                    w_run_nxt = 1'b0;
                end
            end
            S_EXEC: begin
                w_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_selfloop) begin
                    w_set_sl  = 1'b1;
                    w_run_nxt = 1'b0;
                    w_next    = S_HALT;
                end else if (!r_run) begin
                    w_next = S_HALT;
                end else if (w_bp) begin
                    w_set_bp  = 1'b1;
                    w_run_nxt = 1'b0;
                    w_next    = S_HALT;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_ERROR: begin
                w_run_nxt = 1'b0;
                if (clr_err_i) begin
                    w_next = S_HALT;
                end
            end
            default: begin
                w_next = S_HALT;
            end
        endcase
        // stop overrides any start taken in the same cycle
        if (stop_i) begin
            w_run_nxt = 1'b0;
        end
    end

    assign w_enter_fetch = (w_next == S_FETCH) && (r_state != S_FETCH);
    assign w_leave_halt  = (r_state == S_HALT) && (w_next != S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_HALT;
            r_run      <= 1'b0;
            r_halted   <= 1'b1;
            r_addr     <= 4'd0;
            r_instr    <= 8'd0;
            r_to       <= 8'd0;
            r_bp_hit   <= 1'b0;
            r_selfloop <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state  <= w_next;
            r_run    <= w_run_nxt;
            r_halted <= (w_next == S_HALT);
            if (w_enter_fetch) begin
                r_addr <= ip_i;
            end
            if (r_state == S_FETCH && rom_ack_i) begin
                r_instr <= rom_data_i;
            end
            if (r_state == S_FETCH && !rom_ack_i) begin
                r_to <= r_to + 8'd1;
            end else begin
                r_to <= 8'd0;
            end
            if (w_leave_halt) begin
                r_bp_hit   <= 1'b0;
                r_selfloop <= 1'b0;
            end else begin
                if (w_set_bp) r_bp_hit <= 1'b1;
                if (w_set_sl) r_selfloop <= 1'b1;
            end
            if (clr_cnt_i) begin
                r_cnt <= '0;
            end else if (r_state == S_EXEC && r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign rom_req_o    = (r_state == S_FETCH);
    assign rom_addr_o   = r_addr;
    assign exec_en_o    = (r_state == S_EXEC);
    assign instr_o      = r_instr;
    assign halted_o     = r_halted;
    assign bp_hit_o     = r_bp_hit;
    assign selfloop_o   = r_selfloop;
    assign err_o        = (r_state == S_ERROR);
    assign insn_count_o = r_cnt;

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
Run-control sequencer for the 4-bit CPU core. It fetches each instruction from program ROM over a req/ack handshake. It then pulses the datapath's execute strobe so the register-file update (nop/mov/add/jmp/jnc) is applied exactly once per instruction. It also provides start/stop/single-step, a breakpoint, self-loop (JMP-to-self) halt detection, a fetch timeout and an executed-instruction counter.

Parameters:
TIMEOUT, 15, max cycles rom_req_o may stay high without rom_ack_i (1..255)
CNT_W, 16, width of executed-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_i  in  1  pulse: enter free-run mode
stop_i  in  1  pulse: leave free-run mode
step_i  in  1  pulse: execute one instruction (honoured only in HALT)
bp_en_i  in  1  breakpoint enable
bp_addr_i  in  4  breakpoint instruction address
ip_i  in  4  current ip from datapath register file
rom_req_o  out  1  fetch request
rom_addr_o  out  4  fetch address, stable while rom_req_o=1
rom_ack_i  in  1  fetch data valid
rom_data_i  in  8  instruction word {opcode[7:4], imm[3:0]}
exec_en_o  out  1  one-cycle strobe: datapath applies instr_o
instr_o  out  8  latched instruction, valid while exec_en_o=1
halted_o  out  1  1 in HALT state
bp_hit_o  out  1  sticky: last halt caused by breakpoint
selfloop_o  out  1  sticky: last halt caused by JMP-to-self
err_o  out  1  1 in ERROR state
clr_err_i  in  1  pulse: ERROR -> HALT
clr_cnt_i  in  1  pulse: clear insn_count_o
insn_count_o  out  CNT_W  executed instructions, saturating

Behaviour:
- Reset (async, rst_n=0): state HALT, run flag 0. All outputs 0 except halted_o=1. instr_o=0, count=0, timeout counter=0.
- States: HALT, FETCH, EXEC, CHECK, ERROR.
- HALT:
  - start_i -> set run flag, go FETCH.
  - step_i (no start_i) -> run flag stays 0, go FETCH.
  - start_i and step_i together: start wins.
  - Leaving HALT clears bp_hit_o and selfloop_o.
- FETCH:
  - On entry, rom_addr_o<=ip_i; rom_req_o=1 every FETCH cycle.
  - rom_ack_i=1 -> latch rom_data_i into instr_o, drop req, go EXEC.
  - Timeout counter counts FETCH cycles without ack. When counter reaches TIMEOUT with no ack -> ERROR next edge, req dropped.
  - Ack in the timeout cycle: ack wins.
- EXEC (exactly 1 cycle):
  - exec_en_o=1 and instr_o held.
  - insn_count_o increments, saturating at all-ones.
  - go CHECK.
- CHECK (1 cycle; datapath ip now updated). Priority order:
  1. instr_o[7:4]==4'b1111 and instr_o[3:0]==rom_addr_o: selfloop_o<=1, clear run flag, go HALT.
  2. run flag 0 (step mode, or stop taken): go HALT.
  3. bp_en_i and ip_i==bp_addr_i: bp_hit_o<=1, clear run flag, go HALT.
  4. otherwise go FETCH.
- Breakpoint is checked only in CHECK, so the instruction at bp_addr executes normally when resuming from a breakpoint via start/step.
- stop_i: clears run flag in any state. The in-flight instruction completes; halt occurs at the next CHECK. stop_i and start_i in the same cycle: stop wins.
- step_i outside HALT: ignored. start_i while running: no effect.
- ERROR:
  - err_o=1, no requests, no exec strobes, run flag cleared.
  - clr_err_i -> HALT. start_i/step_i ignored in ERROR.
- clr_cnt_i: count <= 0. Takes priority over a same-cycle EXEC increment.
- halted_o is registered and equals (state==HALT).
- Exactly one exec_en_o pulse per rom_ack_i; never two strobes per fetch.
- Minimum loop: FETCH(ack same cycle)-EXEC-CHECK = 3 cycles per instruction.

Test Plan:
- Reset, rom acks immediately, no commands: halted_o=1, rom_req_o=0, exec_en_o=0, insn_count_o=0 indefinitely.
- ip_i=3, step_i pulse, rom_data_i=8'h35: rom_addr_o=3; one exec_en_o with instr_o=8'h35; insn_count_o=1; halted_o=1 four cycles after step.
- Datapath model increments ip, start_i, bp_en_i=1, bp_addr_i=5 from ip=0: five exec strobes (ip 0..4), halt with bp_hit_o=1. Then start_i: instruction at ip 5 executes, bp_hit_o cleared.
- ROM at ip=7 returns 8'hF7, run mode: one exec strobe, then halt with selfloop_o=1, count=1.
- rom_ack_i held 0 with TIMEOUT=15: rom_req_o high 15 cycles then err_o=1. clr_err_i -> halted_o=1. Repeat with ack arriving on the 15th cycle: no error.
- stop_i during FETCH with ack delayed 4 cycles: instruction still executes once, then HALT. clr_cnt_i coincident with exec_en_o -> count=0. Count preloaded near all-ones saturates, no wrap.
